// File: rtl/sd_pkg.sv
// Shared definitions for the SD SPI-mode command controller: FSM states, frame
// constants, fixed CRC bytes and the R1 bit used to tell a response from idle line.
package sd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSend,
        StFlush,
        StPoll,
        StFinish
    } sd_state_e;

    // Every command frame begins with start bit 0 and transmission bit 1.
    localparam logic [1:0] FRAME_START = 2'b01;
    localparam logic [2:0] FRAME_LAST  = 3'd5;

    localparam logic [5:0] CMD0_INDEX = 6'd0;
    localparam logic [5:0] CMD8_INDEX = 6'd8;

    // Precomputed trailer bytes ({CRC7, end bit}) when CRC hardware is absent.
    localparam logic [7:0] CRC_BYTE_CMD0    = 8'h95;
    localparam logic [7:0] CRC_BYTE_CMD8    = 8'h87;
    localparam logic [7:0] CRC_BYTE_DEFAULT = 8'h01;

    // Reads 1 while the card keeps the line idle (FF); 0 marks a valid R1 byte.
    localparam int unsigned R1_IDLE_BIT = 7;

    // Byte 'pos' of the 6-byte command frame.
    function automatic logic [7:0] frame_byte(input logic [5:0]  index,
                                              input logic [31:0] arg,
                                              input logic [2:0]  pos,
                                              input logic [7:0]  crc_byte);
        logic [7:0] b;
        case (pos)
            3'd0:    b = {FRAME_START, index};
            3'd1:    b = arg[31:24];
            3'd2:    b = arg[23:16];
            3'd3:    b = arg[15:8];
            3'd4:    b = arg[7:0];
            3'd5:    b = crc_byte;
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sd_cmd_ctrl_if.sv
// Bundle of the host command handshake and the SPI byte-engine handshake.
// master: the command controller; slave: host plus SPI engine around it.
interface sd_cmd_ctrl_if;

    logic        Start;
    logic [5:0]  CmdIndex;
    logic [31:0] CmdArg;
    logic        Busy;
    logic        Done;
    logic        Timeout;
    logic [7:0]  Resp;

    logic        SpiEnable;
    logic [7:0]  SendData;
    logic        SendReq;
    logic        SendAck;
    logic [7:0]  RecvData;
    logic        RecvAdv;
    logic        RecvAck;

    modport master (
        input  Start, CmdIndex, CmdArg, SendAck, RecvData, RecvAdv,
        output Busy, Done, Timeout, Resp, SpiEnable, SendData, SendReq, RecvAck
    );

    modport slave (
        output Start, CmdIndex, CmdArg, SendAck, RecvData, RecvAdv,
        input  Busy, Done, Timeout, Resp, SpiEnable, SendData, SendReq, RecvAck
    );

endinterface

// File: rtl/sd_crc7.sv
// Byte-serial CRC7 accumulator (x^7 + x^3 + 1, init 0): folds one byte, MSB
// first, on each ByteValid cycle.
module sd_crc7 (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       Clear,
    input  logic       ByteValid,
    input  logic [7:0] DataIn,
    output logic [6:0] Crc
);

    logic [6:0] crc_q;
    logic [6:0] crc_next;
    logic       fb;

    // Eight shift steps of the CRC LFSR over the incoming byte.
    always_comb begin
        crc_next = crc_q;
        fb       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fb       = crc_next[6] ^ DataIn[3'(7 - i)];
            crc_next = {crc_next[5:0], 1'b0};
            if (fb) begin
                crc_next = crc_next ^ 7'h09;
            end
        end
    end

    // Accumulator register; cleared at the start of each command.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            crc_q <= 7'h00;
        end else if (Clear) begin
            crc_q <= 7'h00;
        end else if (ByteValid) begin
            crc_q <= crc_next;
        end
    end

    assign Crc = crc_q;

endmodule

// File: rtl/sd_cmd_ctrl.sv
// SD SPI-mode command controller: sends a 6-byte command frame through a byte
// engine, drops the echo bytes, then polls for the R1 response or times out.
// Build option: define SD_CMD_CRC7_EN to compute the CRC7 trailer in hardware;
// otherwise only CMD0/CMD8 get their fixed CRC and every other command sends 01.
module sd_cmd_ctrl
    import sd_pkg::*;
#(
    parameter int unsigned NCR_MAX = 8
) (
    input  logic          Clk,
    input  logic          nReset,
    sd_cmd_ctrl_if.master bus
);

    sd_state_e   state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  poll_cnt_q, poll_cnt_d;
    logic [5:0]  cmd_index_q, cmd_index_d;
    logic [31:0] cmd_arg_q, cmd_arg_d;
    logic        spi_en_q, spi_en_d;
    logic [7:0]  resp_q, resp_d;
    logic        timeout_q, timeout_d;
    logic        send_ack_q;

    logic        start_ok;
    logic        send_fall;
    logic [7:0]  crc_byte;
    logic [7:0]  frame_cur;

    assign start_ok  = (state_q == StIdle) && bus.Start;
    // The engine drops SendAck once the byte moves into its shifter.
    assign send_fall = send_ack_q && !bus.SendAck;
    assign frame_cur = frame_byte(cmd_index_q, cmd_arg_q, idx_q, crc_byte);

`ifdef SD_CMD_CRC7_EN
    logic [6:0] crc7;

    // Bytes 0..4 are folded in while each is presented in LOAD; byte 5 reads the result.
    sd_crc7 u_crc7 (
        .Clk       (Clk),
        .nReset    (nReset),
        .Clear     (start_ok),
        .ByteValid ((state_q == StLoad) && (idx_q < FRAME_LAST)),
        .DataIn    (frame_cur),
        .Crc       (crc7)
    );

    assign crc_byte = {crc7, 1'b1};
`else
    // Fixed trailer: only the commands issued before CRC is turned off need a real CRC.
    always_comb begin
        if (cmd_index_q == CMD0_INDEX) begin
            crc_byte = CRC_BYTE_CMD0;
        end else if (cmd_index_q == CMD8_INDEX) begin
            crc_byte = CRC_BYTE_CMD8;
        end else begin
            crc_byte = CRC_BYTE_DEFAULT;
        end
    end
`endif

    // State and datapath registers.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= StIdle;
            idx_q       <= 3'd0;
            poll_cnt_q  <= 8'd0;
            cmd_index_q <= 6'd0;
            cmd_arg_q   <= 32'd0;
            spi_en_q    <= 1'b0;
            resp_q      <= 8'hFF;
            timeout_q   <= 1'b0;
            send_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            poll_cnt_q  <= poll_cnt_d;
            cmd_index_q <= cmd_index_d;
            cmd_arg_q   <= cmd_arg_d;
            spi_en_q    <= spi_en_d;
            resp_q      <= resp_d;
            timeout_q   <= timeout_d;
            send_ack_q  <= bus.SendAck;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        poll_cnt_d  = poll_cnt_q;
        cmd_index_d = cmd_index_q;
        cmd_arg_d   = cmd_arg_q;
        spi_en_d    = spi_en_q;
        resp_d      = resp_q;
        timeout_d   = timeout_q;
        case (state_q)
            StIdle: begin
                if (bus.Start) begin
                    cmd_index_d = bus.CmdIndex;
                    cmd_arg_d   = bus.CmdArg;
                    spi_en_d    = 1'b1;
                    idx_d       = 3'd0;
                    timeout_d   = 1'b0;
                    state_d     = StLoad;
                end
            end
            StLoad: state_d = StSend;
            StSend: begin
                if (send_fall) begin
                    if (idx_q < FRAME_LAST) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StLoad;
                    end else begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                // This byte was clocked in while the CRC byte went out.
                if (bus.RecvAdv) begin
                    poll_cnt_d = 8'd0;
                    state_d    = StPoll;
                end
            end
            StPoll: begin
                if (bus.RecvAdv) begin
                    poll_cnt_d = poll_cnt_q + 8'd1;
                    if (!bus.RecvData[R1_IDLE_BIT]) begin
                        resp_d    = bus.RecvData;
                        timeout_d = 1'b0;
                        state_d   = StFinish;
                    end else if (poll_cnt_q + 8'd1 == NCR_MAX[7:0]) begin
                        resp_d    = 8'hFF;
                        timeout_d = 1'b1;
                        state_d   = StFinish;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs decoded from state; RecvAck is gated by RecvAdv so it never fires alone.
    always_comb begin
        bus.Busy      = (state_q != StIdle);
        bus.Done      = (state_q == StFinish);
        bus.Timeout   = timeout_q;
        bus.Resp      = resp_q;
        bus.SpiEnable = spi_en_q;
        bus.SendReq   = (state_q == StLoad);
        bus.SendData  = ((state_q == StLoad) || (state_q == StSend)) ? frame_cur : 8'hFF;
        bus.RecvAck   = bus.RecvAdv && ((state_q == StLoad) || (state_q == StSend) ||
                                        (state_q == StFlush) || (state_q == StPoll));
    end

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Directed bench for sd_cmd_ctrl with a behavioural SPI byte engine.
module tb_sd_cmd_ctrl;

    localparam int unsigned NCR = 8;

    logic Clk = 1'b0;
    logic nReset = 1'b0;

    sd_cmd_ctrl_if bus ();

    sd_cmd_ctrl #(
        .NCR_MAX (NCR)
    ) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard fed by the engine model.
    logic [7:0] sent_q [$];
    logic [7:0] poll_q [$];
    int         req_cnt = 0;
    int         done_cnt = 0;
    int         ack_cnt = 0;
    int         cyc = 0;
    int         last_ack_cyc = 0;
    int         done_cyc = 0;
    logic [7:0] done_resp = 8'h00;
    logic       done_to = 1'b0;

    // Engine internals.
    logic       pending = 1'b0;
    logic       shifting = 1'b0;
    int         load_dly = 0;
    int         shift_cnt = 0;
    int         loaded = 0;
    logic [7:0] rx_next = 8'hFF;
    logic       req_s, ack_s, busy_s, done_s, en_s;
    logic [7:0] data_s;

    function automatic logic [6:0] crc7_of(input logic [39:0] bytes);
        logic [6:0] c = 7'h00;
        logic       f;
        for (int i = 39; i >= 0; i--) begin
            f = c[6] ^ bytes[i];
            c = {c[5:0], 1'b0};
            if (f) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [7:0] exp_crc(input logic [5:0] idx, input logic [31:0] arg);
`ifdef SD_CMD_CRC7_EN
        return {crc7_of({2'b01, idx, arg}), 1'b1};
`else
        if (idx == 6'd0) return 8'h95;
        if (idx == 6'd8) return 8'h87;
        return 8'h01;
`endif
    endfunction

    // SPI byte engine: samples DUT outputs on the falling edge, updates after the rising edge.
    initial begin
        bus.SendAck  = 1'b0;
        bus.RecvAdv  = 1'b0;
        bus.RecvData = 8'hFF;
        forever begin
            @(negedge Clk);
            cyc++;
            req_s  = bus.SendReq;
            ack_s  = bus.RecvAck;
            busy_s = bus.Busy;
            done_s = bus.Done;
            en_s   = bus.SpiEnable;
            data_s = bus.SendData;
            if (req_s) begin
                req_cnt++;
                sent_q.push_back(data_s);
            end
            if (ack_s) begin
                ack_cnt++;
                last_ack_cyc = cyc;
            end
            if (done_s) begin
                done_cnt++;
                done_cyc  = cyc;
                done_resp = bus.Resp;
                done_to   = bus.Timeout;
            end
            @(posedge Clk);
            #1;
            if (!nReset) begin
                bus.SendAck = 1'b0;
                bus.RecvAdv = 1'b0;
                pending     = 1'b0;
                shifting    = 1'b0;
                loaded      = 0;
            end else begin
                if (ack_s) bus.RecvAdv = 1'b0;
                if (!busy_s) loaded = 0;
                if (req_s) begin
                    pending     = 1'b1;
                    bus.SendAck = 1'b1;
                    load_dly    = 2;
                end
                if (shifting) begin
                    if (shift_cnt == 0) begin
                        shifting     = 1'b0;
                        bus.RecvAdv  = 1'b1;
                        bus.RecvData = rx_next;
                    end else begin
                        shift_cnt--;
                    end
                end else if (!bus.RecvAdv && en_s) begin
                    if (pending) begin
                        if (load_dly == 0) begin
                            pending     = 1'b0;
                            bus.SendAck = 1'b0;
                            shifting    = 1'b1;
                            shift_cnt   = 3;
                            loaded++;
                            rx_next     = 8'hFF;
                        end else begin
                            load_dly--;
                        end
                    end else if (loaded >= 6 && busy_s && !done_s && !ack_s) begin
                        shifting  = 1'b1;
                        shift_cnt = 3;
                        if (poll_q.size() > 0) rx_next = poll_q.pop_front();
                        else rx_next = 8'hFF;
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ".busy"},    bus.Busy,      0);
        check_val({tag, ".done"},    bus.Done,      0);
        check_val({tag, ".timeout"}, bus.Timeout,   0);
        check_val({tag, ".resp"},    bus.Resp,      8'hFF);
        check_val({tag, ".spi_en"},  bus.SpiEnable, 0);
        check_val({tag, ".sdata"},   bus.SendData,  8'hFF);
        check_val({tag, ".sreq"},    bus.SendReq,   0);
        check_val({tag, ".rack"},    bus.RecvAck,   0);
    endtask

    task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [7:0] crc, input logic [7:0] resp, input logic to,
                           input int polls, input bit glitch);
        logic [7:0] exp_frame [6];
        int         waited;
        exp_frame = '{{2'b01, idx}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], crc};
        sent_q.delete();
        req_cnt  = 0;
        done_cnt = 0;
        ack_cnt  = 0;
        @(posedge Clk); #2;
        bus.CmdIndex = idx;
        bus.CmdArg   = arg;
        bus.Start    = 1'b1;
        @(posedge Clk); #2;
        bus.Start    = 1'b0;
        bus.CmdIndex = 6'h3F;
        bus.CmdArg   = 32'hFFFF_FFFF;
        check_val({tag, ".busy"}, bus.Busy, 1);
        if (glitch) begin
            repeat (6) @(posedge Clk);
            #2;
            bus.CmdIndex = 6'd17;
            bus.Start    = 1'b1;
            @(posedge Clk); #2;
            bus.Start    = 1'b0;
        end
        waited = 0;
        while (done_cnt == 0 && waited < 2000) begin
            @(posedge Clk);
            waited++;
        end
        check_val({tag, ".done_seen"}, (done_cnt > 0), 1);
        repeat (5) @(posedge Clk);
        #2;
        check_val({tag, ".done_cnt"}, done_cnt, 1);
        check_val({tag, ".timeout"}, done_to, to);
        check_val({tag, ".resp"}, done_resp, resp);
        check_val({tag, ".sreq_cnt"}, req_cnt, 6);
        check_val({tag, ".sent_len"}, sent_q.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < sent_q.size()) check_val($sformatf("%s.byte%0d", tag, k), sent_q[k],
                                             exp_frame[k]);
        end
        check_val({tag, ".rack_cnt"}, ack_cnt, 6 + polls);
        check_val({tag, ".latency"}, done_cyc - last_ack_cyc, 1);
        check_val({tag, ".busy_end"}, bus.Busy, 0);
        check_val({tag, ".spi_en_end"}, bus.SpiEnable, 1);
    endtask

    initial begin
        int waited;
        bus.Start    = 1'b0;
        bus.CmdIndex = 6'd0;
        bus.CmdArg   = 32'd0;
        nReset       = 1'b0;
        repeat (3) @(posedge Clk);
        #2;
        check_reset_outputs("rst");
        nReset = 1'b1;

        poll_q = '{8'hFF, 8'hFF, 8'h01};
        run_cmd("cmd0", 6'd0, 32'h0, 8'h95, 8'h01, 1'b0, 3, 1'b0);

        poll_q = '{8'hFF, 8'h01};
        run_cmd("cmd8", 6'd8, 32'h0000_01AA, 8'h87, 8'h01, 1'b0, 2, 1'b0);

        poll_q.delete();
        run_cmd("cmd55_to", 6'd55, 32'h0, exp_crc(6'd55, 32'h0), 8'hFF, 1'b1, NCR, 1'b0);

        poll_q = '{8'h01};
        run_cmd("cmd8_glitch", 6'd8, 32'h0000_01AA, 8'h87, 8'h01, 1'b0, 1, 1'b1);

        // Abort a command after its third frame byte.
        sent_q.delete();
        req_cnt  = 0;
        done_cnt = 0;
        poll_q   = '{8'h01};
        @(posedge Clk); #2;
        bus.CmdIndex = 6'd0;
        bus.CmdArg   = 32'h0;
        bus.Start    = 1'b1;
        @(posedge Clk); #2;
        bus.Start = 1'b0;
        waited = 0;
        while (req_cnt < 3 && waited < 500) begin
            @(posedge Clk);
            waited++;
        end
        check_val("midrst.reached3", (req_cnt >= 3), 1);
        repeat (2) @(posedge Clk);
        #2;
        nReset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(posedge Clk);
        #2;
        check_val("midrst.no_done", done_cnt, 0);
        nReset = 1'b1;
        poll_q = '{8'h01};
        run_cmd("cmd0_after_rst", 6'd0, 32'h0, 8'h95, 8'h01, 1'b0, 1, 1'b0);

        poll_q = '{8'hFF, 8'h00};
        run_cmd("cmd17", 6'd17, 32'h0000_1000, exp_crc(6'd17, 32'h0000_1000), 8'h00, 1'b0, 2,
                1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
